// File: rtl/divider_seq_pkg.sv
// Shared constants for the sequential signed divider: default width and
// FSM state encodings.
package divider_seq_pkg;

    // Default divisor/remainder width; dividend/quotient are twice this.
    localparam int N_DEF = 4;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration on magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep or restore.
module divider_step
    import divider_seq_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N:0]   prem,
    input  logic         din,
    input  logic [N-1:0] dvs,
    output logic [N:0]   prem_next,
    output logic         qbit
);

    logic [N+1:0] shifted;
    logic [N:0]   diff;

    // The partial remainder is always below the divisor, so the shifted
    // value fits in N+1 bits; the extra top bit only feeds the compare.
    assign shifted   = {prem, din};
    assign diff      = shifted[N:0] - {1'b0, dvs};
    assign qbit      = (shifted >= {2'b00, dvs});
    assign prem_next = qbit ? diff : shifted[N:0];

endmodule

// File: rtl/divider_seq.sv
// Iterative signed divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock on magnitudes, then a sign-fix cycle. Truncates toward zero.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             ovf
);

    localparam int CNT_W = $clog2(2*N+1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   dvd_sh;     // dividend magnitude, becomes quotient magnitude
    logic [N-1:0]     dvs_mag;
    logic [N:0]       prem;
    logic             sgn_dvd;
    logic             sgn_dvs;
    logic             dz;

    logic [2*N-1:0]   dvd_abs;
    logic [N-1:0]     dvs_abs;
    logic [N:0]       prem_next;
    logic             qbit;
    logic             neg_q;
    logic [2*N-1:0]   q_signed;
    logic [N-1:0]     r_signed;

    assign dvd_abs  = dividend[2*N-1] ? -dividend : dividend;
    assign dvs_abs  = divisor[N-1] ? -divisor : divisor;
    assign neg_q    = sgn_dvd ^ sgn_dvs;
    assign q_signed = neg_q ? -dvd_sh : dvd_sh;
    assign r_signed = sgn_dvd ? -prem[N-1:0] : prem[N-1:0];
    assign busy     = (state != ST_IDLE);

    divider_step #(.N(N)) u_step (
        .prem      (prem),
        .din       (dvd_sh[2*N-1]),
        .dvs       (dvs_mag),
        .prem_next (prem_next),
        .qbit      (qbit)
    );

    // FSM, iteration counter, datapath registers and result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dvd_sh    <= '0;
            dvs_mag   <= '0;
            prem      <= '0;
            sgn_dvd   <= 1'b0;
            sgn_dvs   <= 1'b0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sgn_dvd <= dividend[2*N-1];
                        sgn_dvs <= divisor[N-1];
                        dvd_sh  <= dvd_abs;
                        dvs_mag <= dvs_abs;
                        prem    <= '0;
                        if (divisor == '0) begin
                            // Nothing to iterate; go straight to result.
                            dz    <= 1'b1;
                            cnt   <= '0;
                            state <= ST_FIX;
                        end else begin
                            dz    <= 1'b0;
                            cnt   <= CNT_W'(2*N);
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    prem   <= prem_next;
                    dvd_sh <= {dvd_sh[2*N-2:0], qbit};
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                    if (dz) begin
                        quotient  <= '0;
                        remainder <= '0;
                        div_zero  <= 1'b1;
                        ovf       <= 1'b0;
                    end else begin
                        quotient  <= q_signed;
                        remainder <= r_signed;
                        div_zero  <= 1'b0;
                        // Magnitude 2^(2N-1) is only representable when negative.
                        ovf       <= ~neg_q & dvd_sh[2*N-1];
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed cases with literal results,
// then randomized traffic checked every cycle against an arithmetic model.
module tb_divider_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;
    logic       ovf;

    int total = 0;
    int bad = 0;

    // Model state: expected results {q, r, div_zero, ovf} and the done cycle.
    logic [13:0] exp_q[$];
    logic [13:0] held = '0;
    bit          pend = 1'b0;
    int          due = 0;
    int          cyc = 0;

    divider_seq #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Signed division truncating toward zero, straight from integer arithmetic.
    function automatic logic [13:0] ref_div(input logic [7:0] a, input logic [3:0] b);
        int   sa;
        int   sb;
        int   q;
        int   r;
        logic ov;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) return {8'h00, 4'h0, 2'b10};
        q  = sa / sb;
        r  = sa % sb;
        ov = (sa == -128) && (sb == -1);
        return {q[7:0], r[3:0], 1'b0, ov};
    endfunction

    // Per-cycle compare against the model; also records accepted starts.
    always @(negedge clk) begin : chk
        bit exp_done;
        cyc++;
        if (rst) begin
            pend = 1'b0;
            exp_q.delete();
            held = '0;
        end
        exp_done = 1'b0;
        if (pend && cyc == due) begin
            held     = exp_q.pop_front();
            pend     = 1'b0;
            exp_done = 1'b1;
        end
        check("done", 32'(done), 32'(exp_done));
        check("busy", 32'(busy), 32'(pend));
        check("quotient", 32'(quotient), 32'(held[13:6]));
        check("remainder", 32'(remainder), 32'(held[5:2]));
        check("div_zero", 32'(div_zero), 32'(held[1]));
        check("ovf", 32'(ovf), 32'(held[0]));
        if (!rst && start && !pend) begin
            exp_q.push_back(ref_div(dividend, divisor));
            due  = cyc + 1 + ((divisor == 4'h0) ? 1 : 9);
            pend = 1'b1;
        end
    end

    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n >= 30) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within 30 cycles");
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    task automatic op(input string name, input logic [7:0] a, input logic [3:0] b,
                      input int lat, input logic [7:0] eq, input logic [3:0] er,
                      input logic edz, input logic eov);
        int n;
        issue(a, b);
        wait_done(n);
        check({name, "_lat"}, 32'(n), 32'(lat));
        check({name, "_q"}, 32'(quotient), 32'(eq));
        check({name, "_r"}, 32'(remainder), 32'(er));
        check({name, "_dz"}, 32'(div_zero), 32'(edz));
        check({name, "_ovf"}, 32'(ovf), 32'(eov));
    endtask

    logic [7:0] ra;
    logic [3:0] rb;

    // Stimulus: reset, model pins, directed cases, then random traffic.
    initial begin
        int n;
        int nd;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", 32'(quotient), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        check("pin_12_4", 32'(ref_div(8'd12, 4'd4)), 32'({8'h03, 4'h0, 2'b00}));
        check("pin_m7_2", 32'(ref_div(8'hF9, 4'h2)), 32'({8'hFD, 4'hF, 2'b00}));
        check("pin_ovf", 32'(ref_div(8'h80, 4'hF)), 32'({8'h80, 4'h0, 2'b01}));
        check("pin_127_m8", 32'(ref_div(8'h7F, 4'h8)), 32'({8'hF1, 4'h7, 2'b00}));

        op("d12_4",   8'd12, 4'd4, 9, 8'h03, 4'h0, 1'b0, 1'b0);
        op("dm7_2",   8'hF9, 4'h2, 9, 8'hFD, 4'hF, 1'b0, 1'b0);
        op("d1_m1",   8'h01, 4'hF, 9, 8'hFF, 4'h0, 1'b0, 1'b0);
        op("d5_0",    8'h05, 4'h0, 1, 8'h00, 4'h0, 1'b1, 1'b0);
        op("d4_m2",   8'h04, 4'hE, 9, 8'hFE, 4'h0, 1'b0, 1'b0);
        op("dmin_m1", 8'h80, 4'hF, 9, 8'h80, 4'h0, 1'b0, 1'b1);
        op("d127_m8", 8'h7F, 4'h8, 9, 8'hF1, 4'h7, 1'b0, 1'b0);

        // Start while busy must be ignored.
        issue(8'd12, 4'd4);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; dividend = 8'd5; divisor = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("ign_q", 32'(quotient), 32'h03);
        check("ign_r", 32'(remainder), 32'h0);
        count_dones(20, nd);
        check("ign_extra_done", 32'(nd), 32'h0);

        // Reset mid-operation clears everything at once.
        issue(8'd100, 4'd3);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_q", 32'(quotient), 32'h0);
        check("rst_r", 32'(remainder), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_flags", 32'({div_zero, ovf}), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_dones(20, nd);
        check("rst_no_done", 32'(nd), 32'h0);

        // Back-to-back: second start in the done cycle.
        @(posedge clk);
        #1;
        start = 1'b1; dividend = 8'd9; divisor = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("b2b_first_done", 32'(done), 32'h1);
        check("b2b_first_q", 32'(quotient), 32'h03);
        start = 1'b1; dividend = 8'd6; divisor = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("b2b_lat", 32'(n), 32'd9);
        check("b2b_q", 32'(quotient), 32'h02);
        check("b2b_r", 32'(remainder), 32'h0);

        // Random traffic; inputs change every cycle, rare resets.
        repeat (3000) begin
            @(posedge clk);
            #1;
            case ($urandom_range(0, 9))
                0: ra = 8'h80;
                1: ra = 8'h7F;
                2: ra = 8'h00;
                default: ra = 8'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0: rb = 4'h0;
                1: rb = 4'hF;
                2: rb = 4'h8;
                3: rb = 4'h1;
                default: rb = 4'($urandom);
            endcase
            start    = ($urandom_range(0, 3) == 0);
            dividend = ra;
            divisor  = rb;
            rst      = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        repeat (20) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
